// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM access arbiter.
// Latency: none (declarations only); backpressure: n/a.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RD_CAP = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin pick: a tie goes to the port that did not win last.
// Latency: combinational; backpressure: requesters hold req until served.
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_id_o    = PORT0;
        if (req0_i && req1_i) begin
            grant_id_o = (last_grant_i == PORT0) ? PORT1 : PORT0;
        end else if (req1_i) begin
            grant_id_o = PORT1;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one 16x8 RAM between two req/done ports and owns the controller side of its data bus.
// Latency: read done 3 cycles, write done 2 cycles after grant; requesters wait by holding req.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              done1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_R_W,
    inout  wire  [DATA_W-1:0] mem_Data_Bus
);

    state_t            state_q;
    logic              gnt_id_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_rw_q;
    logic              bus_oe_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              done0_q;
    logic              done1_q;

    logic              grant_valid;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter_2 u_rr (
        .req0_i        (req0),
        .req1_i        (req1),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (grant_id == PORT1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // Default each cycle: bus released, RAM reading, no done pulse. Only WR overrides the bus pair.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            gnt_id_q      <= PORT0;
            last_grant_q  <= PORT1;
            mem_address_q <= '0;
            mem_rw_q      <= 1'b1;
            bus_oe_q      <= 1'b0;
            wdata_q       <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
        end else begin
            mem_rw_q <= 1'b1;
            bus_oe_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        gnt_id_q      <= grant_id;
                        last_grant_q  <= grant_id;
                        mem_address_q <= sel_addr;
                        if (sel_we) begin
                            wdata_q  <= sel_wdata;
                            mem_rw_q <= 1'b0;
                            bus_oe_q <= 1'b1;
                            state_q  <= ST_WR;
                        end else begin
                            state_q  <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state_q <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    // RAM is presenting the word registered on the previous edge.
                    if (gnt_id_q == PORT0) begin
                        rdata0_q <= mem_Data_Bus;
                        done0_q  <= 1'b1;
                    end else begin
                        rdata1_q <= mem_Data_Bus;
                        done1_q  <= 1'b1;
                    end
                    state_q <= ST_DONE;
                end
                ST_WR: begin
                    done0_q <= (gnt_id_q == PORT0);
                    done1_q <= (gnt_id_q == PORT1);
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_Data_Bus = bus_oe_q ? wdata_q : {DATA_W{1'bz}};

    assign mem_address = mem_address_q;
    assign mem_R_W     = mem_rw_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a registered-read 16x8 RAM model on the shared bus.
module tb_ram_access_arbiter;

    logic       CLK;
    logic       RST;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic [7:0] rdata0, rdata1;
    logic       done0, done1, busy;
    logic [3:0] mem_address;
    logic       mem_R_W;
    wire  [7:0] data_bus;

    logic [7:0] ram_mem [16];
    logic [7:0] ram_dout;
    logic       ram_load;

    int checks;
    int errors;

    ram_access_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .rdata0       (rdata0),
        .done0        (done0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .rdata1       (rdata1),
        .done1        (done1),
        .busy         (busy),
        .mem_address  (mem_address),
        .mem_R_W      (mem_R_W),
        .mem_Data_Bus (data_bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: registers the addressed word while reading, drives it whenever R_W=1.
    assign data_bus = mem_R_W ? ram_dout : 8'bz;

    always @(posedge CLK) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'(i * 17);
            ram_dout <= 8'h00;
        end else if (mem_R_W) begin
            ram_dout <= ram_mem[mem_address];
        end else begin
            ram_mem[mem_address] <= data_bus;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // While R_W=1 only the RAM may drive; any controller drive corrupts the RAM's word.
    always @(negedge CLK) begin
        if (mem_R_W === 1'b1) check("bus_owner", 32'(data_bus), 32'(ram_dout));
        check("done_overlap", 32'(done0 & done1), 32'h0);
    end

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        ram_load = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 4'h0; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 4'h0; wdata1 = 8'h00;
        tick();
        tick();
        ram_load = 1'b0;

        check("rst_busy",   32'(busy),        32'h0);
        check("rst_rw",     32'(mem_R_W),     32'h1);
        check("rst_addr",   32'(mem_address), 32'h0);
        check("rst_done0",  32'(done0),       32'h0);
        check("rst_done1",  32'(done1),       32'h0);
        check("rst_rdata0", 32'(rdata0),      32'h0);
        check("rst_rdata1", 32'(rdata1),      32'h0);
        RST = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        // Port 0 write A5 -> 3
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5;
        tick();
        check("wr_rw",    32'(mem_R_W),     32'h0);
        check("wr_bus",   32'(data_bus),    32'hA5);
        check("wr_addr",  32'(mem_address), 32'h3);
        check("wr_done0", 32'(done0),       32'h0);
        check("wr_busy",  32'(busy),        32'h1);
        tick();
        check("wr_done0_hi", 32'(done0),   32'h1);
        check("wr_rw_back",  32'(mem_R_W), 32'h1);
        check("wr_done1",    32'(done1),   32'h0);
        req0 = 1'b0; we0 = 1'b0;
        tick();
        check("wr_done0_lo", 32'(done0),      32'h0);
        check("wr_idle",     32'(busy),       32'h0);
        check("wr_ram3",     32'(ram_mem[3]), 32'hA5);

        // Port 1 read of 3; address change after grant must be ignored
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
        tick();
        check("rd_rw",    32'(mem_R_W),     32'h1);
        check("rd_addr",  32'(mem_address), 32'h3);
        check("rd_done1", 32'(done1),       32'h0);
        addr1 = 4'hF;
        tick();
        check("rdcap_done1", 32'(done1),   32'h0);
        check("rdcap_rw",    32'(mem_R_W), 32'h1);
        tick();
        check("rd_done1_hi", 32'(done1),  32'h1);
        check("rd_rdata1",   32'(rdata1), 32'hA5);
        check("rd_rdata0",   32'(rdata0), 32'h0);
        req1 = 1'b0;
        tick();
        check("rd_done1_lo", 32'(done1), 32'h0);
        check("rd_idle",     32'(busy),  32'h0);

        // Simultaneous reads after reset: port 0 first
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst2_rdata1", 32'(rdata1), 32'h0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
        tick();
        check("tie_addr0", 32'(mem_address), 32'h1);
        tick();
        tick();
        check("tie_done0",  32'(done0),  32'h1);
        check("tie_done1",  32'(done1),  32'h0);
        check("tie_rdata0", 32'(rdata0), 32'h11);
        req0 = 1'b0;
        tick();
        check("tie_gap_busy", 32'(busy), 32'h0);
        tick();
        check("tie_busy1", 32'(busy),        32'h1);
        check("tie_addr1", 32'(mem_address), 32'h2);
        tick();
        tick();
        check("tie_done1_hi", 32'(done1),  32'h1);
        check("tie_done0_lo", 32'(done0),  32'h0);
        check("tie_rdata1",   32'(rdata1), 32'h22);
        check("tie_rdata0_k", 32'(rdata0), 32'h11);
        req1 = 1'b0;
        tick();
        check("tie_idle", 32'(busy), 32'h0);

        // Both ports requesting continuously: grants alternate starting with port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h5;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h6;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("fair_busy", 32'(busy), 32'h1);
            check("fair_addr", 32'(mem_address), (k % 2 == 1) ? 32'h6 : 32'h5);
            tick();
            tick();
            check("fair_done0", 32'(done0), (k % 2 == 0) ? 32'h1 : 32'h0);
            check("fair_done1", 32'(done1), (k % 2 == 1) ? 32'h1 : 32'h0);
            if (k % 2 == 0) check("fair_rdata0", 32'(rdata0), 32'h55);
            else            check("fair_rdata1", 32'(rdata1), 32'h66);
            tick();
            check("fair_gap", 32'(busy), 32'h0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Write 3C -> 7, then a write of FF aborted by reset mid-WR
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = 8'h3C;
        tick();
        check("w7_bus", 32'(data_bus), 32'h3C);
        tick();
        check("w7_done0", 32'(done0), 32'h1);
        req0 = 1'b0;
        tick();
        check("w7_ram", 32'(ram_mem[7]), 32'h3C);
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = 8'hFF;
        tick();
        check("abort_wr_rw",  32'(mem_R_W),  32'h0);
        check("abort_wr_bus", 32'(data_bus), 32'hFF);
        #3;
        RST = 1'b1;
        #1;
        check("abort_rw",     32'(mem_R_W),     32'h1);
        check("abort_bus",    32'(data_bus),    32'(ram_dout));
        check("abort_busy",   32'(busy),        32'h0);
        check("abort_done0",  32'(done0),       32'h0);
        check("abort_addr",   32'(mem_address), 32'h0);
        check("abort_rdata0", 32'(rdata0),      32'h0);
        check("abort_rdata1", 32'(rdata1),      32'h0);
        req0 = 1'b0; we0 = 1'b0;
        tick();
        check("abort_no_done", 32'(done0),      32'h0);
        check("abort_ram7",    32'(ram_mem[7]), 32'h3C);
        RST = 1'b0;
        tick();
        check("post_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Two-port request/acknowledge controller that shares the single 16x8 RAM between two requesters: port 0 is the CPU fetch/execute path and port 1 is the loader/IO path. It sequences the RAM's R_W line and address, and owns the controller side of the shared tri-state data bus. It guarantees that only one agent drives Data_Bus at a time. It returns read data and completion pulses to each requester, and serves simultaneous requests round-robin.

Parameters:
ADDR_W, 4, RAM address width (16 words)
DATA_W, 8, RAM word width

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
req0  in  1  port 0 request; held until done0
we0  in  1  port 0 write enable (1=write, 0=read), valid while req0
addr0  in  ADDR_W  port 0 address, valid while req0
wdata0  in  DATA_W  port 0 write data, valid while req0 && we0
rdata0  out  DATA_W  port 0 read data, valid with done0, held until next port 0 read completes
done0  out  1  one-cycle completion pulse for port 0
req1, we1, addr1, wdata1, rdata1, done1  same as port 0, for port 1
busy  out  1  high in any state other than IDLE
mem_address  out  ADDR_W  to RAM address
mem_R_W  out  1  to RAM R_W (1=read/RAM drives bus, 0=write)
mem_Data_Bus  inout  DATA_W  shared RAM data bus

Behaviour:
- Reset (async, immediate): state=IDLE, mem_R_W=1, mem_address=0, bus_oe=0 (mem_Data_Bus=Z), done0=done1=0, rdata0=rdata1=0, busy=0, last_grant=1 (port 0 wins first tie).
- States: IDLE, RD, RD_CAP, WR, DONE. All RAM-side outputs, done pulses and rdata are registered.
- IDLE: requests are sampled at the clock edge.
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port != last_grant.
  - On grant: latch port id, we, addr and wdata; set last_grant=port; load mem_address=addr; go to RD (we=0) or WR (we=1).
- RD (1 cycle): mem_R_W=1. The RAM registers its word at this edge. Next state RD_CAP.
- RD_CAP (1 cycle): the RAM drives the bus. The controller samples mem_Data_Bus at this edge into rdata of the granted port, sets that port's done for the next cycle, and goes to DONE.
- WR (1 cycle): mem_R_W=0 and bus_oe=1 in the same registered cycle, driving the latched wdata. The RAM stores the word at this edge. Next: DONE with done=1 for the granted port; mem_R_W returns to 1 and bus_oe to 0.
- DONE (1 cycle): done of the granted port is high, requests are ignored, mem_R_W=1. Next state IDLE.
- Requester contract: drop req on the edge that sees done. A req still high in the following IDLE cycle is a new request.
- Latency, from the edge that samples req to done high:
  - Read: 3 cycles (IDLE->RD->RD_CAP->DONE).
  - Write: 2 cycles (IDLE->WR->DONE).
  - Back-to-back throughput: read every 4 cycles, write every 3 cycles.
- Bus ownership: bus_oe=1 only in WR, and always coincident with mem_R_W=0. The controller never drives the bus while mem_R_W=1, so there is no contention.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1,... A single requester is served back-to-back with no penalty.
- Inputs changing while granted have no effect; the latched values are used.
- Reset mid-operation:
  - Access is aborted and no done is issued.
  - During WR, reset forces mem_R_W=1 and Z on the bus immediately. A write whose edge has not yet occurred is not committed.
  - The rdata registers clear.
- Address width: there is no range check; the full 4-bit address space is valid.

Decomposition:
- Package ram_arb_pkg: ADDR_W/DATA_W defaults, state encoding constants (IDLE, RD, RD_CAP, WR, DONE), port-id constants.
- Sub-module rr_arbiter_2:
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_id.
  - Combinational; last_grant is held in the parent.
- Tri-state driver is a single continuous assignment in the top module. The RAM model is instantiated only in the testbench.

Test Plan:
- Reset then port 0 write addr 4'h3 data 8'hA5 -> mem_R_W=0 with bus=A5 for exactly 1 cycle; done0 2 cycles after the sampling edge; RAM[3]=A5.
- Port 1 read addr 4'h3 after the above -> mem_R_W stays 1, bus never driven by the controller; done1 3 cycles after the sampling edge with rdata1=8'hA5.
- req0 and req1 asserted on the same edge after reset (reads of 4'h1 and 4'h2) -> port 0 served first, then port 1; rdata values match RAM contents; done0 and done1 never overlap.
- Both ports holding req continuously for 6 accesses -> grant order 0,1,0,1,0,1; busy low only in single IDLE cycles between accesses.
- Write to 4'h7 (8'h3C), then write 8'hFF to 4'h7 with RST asserted mid-WR before the clock edge -> bus goes Z and mem_R_W=1 immediately; no done; RAM[7] remains 3C; all outputs at reset values.
- Bus contention check across all tests -> the controller drives mem_Data_Bus only while mem_R_W=0 (assertion-checked every cycle).
